// File: rtl/tdm_demux2.sv
// Two-slot TDM receiver: aligns on sync, deserialises A then B slots MSB-first.
// Word outputs update on the edge sampling a slot's last bit; no backpressure, every frame is consumed.
module tdm_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             a_valid,
  output logic             b_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    RECV_A = 2'd1,
    RECV_B = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]  r_sr, w_sr_nxt;
  logic [WIDTH-1:0]  r_a_out, w_a_out_nxt;
  logic [WIDTH-1:0]  r_b_out, w_b_out_nxt;
  logic              r_a_valid, w_a_valid_nxt;
  logic              r_b_valid, w_b_valid_nxt;
  logic              r_locked, w_locked_nxt;
  logic              r_sync_err, w_sync_err_nxt;
  logic [WIDTH-1:0]  w_sr_shift;

  assign w_sr_shift = {r_sr[WIDTH-2:0], din};

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sr_nxt       = r_sr;
    w_a_out_nxt    = r_a_out;
    w_b_out_nxt    = r_b_out;
    w_a_valid_nxt  = 1'b0;
    w_b_valid_nxt  = 1'b0;
    w_locked_nxt   = r_locked;
    w_sync_err_nxt = 1'b0;

    case (r_state)
      HUNT: begin
        if (sync) begin
          w_sr_nxt    = w_sr_shift;
          w_cnt_nxt   = ONE;
          w_state_nxt = RECV_A;
        end
      end

      RECV_A: begin
        if (r_cnt == '0) begin
          // Frame boundary: a missing strobe means alignment is lost.
          if (!sync) begin
            w_sync_err_nxt = 1'b1;
            w_locked_nxt   = 1'b0;
            w_cnt_nxt      = '0;
            w_state_nxt    = HUNT;
          end else begin
            w_sr_nxt  = w_sr_shift;
            w_cnt_nxt = ONE;
          end
        end else if (sync) begin
          w_sync_err_nxt = 1'b1;
          w_locked_nxt   = 1'b0;
          w_sr_nxt       = w_sr_shift;
          w_cnt_nxt      = ONE;
        end else begin
          w_sr_nxt = w_sr_shift;
          if (r_cnt == LAST) begin
            w_a_out_nxt   = w_sr_shift;
            w_a_valid_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = RECV_B;
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
      end

      RECV_B: begin
        // Any strobe inside B restarts the frame with this bit as A's MSB.
        if (sync) begin
          w_sync_err_nxt = 1'b1;
          w_locked_nxt   = 1'b0;
          w_sr_nxt       = w_sr_shift;
          w_cnt_nxt      = ONE;
          w_state_nxt    = RECV_A;
        end else begin
          w_sr_nxt = w_sr_shift;
          if (r_cnt == LAST) begin
            w_b_out_nxt   = w_sr_shift;
            w_b_valid_nxt = 1'b1;
            w_locked_nxt  = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = RECV_A;
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_a_out    <= '0;
      r_b_out    <= '0;
      r_a_valid  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_locked   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sr       <= w_sr_nxt;
      r_a_out    <= w_a_out_nxt;
      r_b_out    <= w_b_out_nxt;
      r_a_valid  <= w_a_valid_nxt;
      r_b_valid  <= w_b_valid_nxt;
      r_locked   <= w_locked_nxt;
      r_sync_err <= w_sync_err_nxt;
    end
  end

  assign a_out    = r_a_out;
  assign b_out    = r_b_out;
  assign a_valid  = r_a_valid;
  assign b_valid  = r_b_valid;
  assign locked   = r_locked;
  assign sync_err = r_sync_err;

endmodule
